// File: rtl/db_ram_pkg.sv
// Shared widths and burst-engine state type for the deblocking RAM controller.
package db_ram_pkg;

  localparam int DB_RAM_DATA_W = 20;
  localparam int DB_RAM_ADDR_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bst_state_e;

endpackage

// File: rtl/db_rr_arb2.sv
// Two-requester round-robin arbiter for RAM port A.
// The pointer only moves when both requesters compete, so a lone requester
// never steals the other's next turn.
module db_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic ptr_q, ptr_d;

  // Grant decision and pointer update; grants are suppressed during reset.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    ptr_d  = ptr_q;
    if (!rst) begin
      if (req0_i && req1_i) begin
        gnt0_o = ~ptr_q;
        gnt1_o = ptr_q;
        ptr_d  = ~ptr_q;
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/db_ram_dp_ctrl.sv
// Access controller for the 20x128 deblocking dual-port SRAM.
// Port A: two arbitrated single-word requesters. Port B: burst-read engine.
//
// state | meaning
// IDLE  | waiting for rd_start_i
// RUN   | issuing one port-B read per cycle (stalls on port-A write collision)
// DRAIN | last read data returning; rd_valid_o and rd_done_o high
module db_ram_dp_ctrl
  import db_ram_pkg::*;
#(
  parameter int DATA_W = DB_RAM_DATA_W,
  parameter int ADDR_W = DB_RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              rd_start_i,
  input  logic [ADDR_W-1:0] rd_base_i,
  input  logic [ADDR_W-1:0] rd_len_i,
  output logic              rd_busy_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_done_o,
  output logic              ram_cena_o,
  output logic              ram_oena_o,
  output logic              ram_wena_o,
  output logic [ADDR_W-1:0] ram_addra_o,
  output logic [DATA_W-1:0] ram_dataa_o,
  input  logic [DATA_W-1:0] ram_dataa_i,
  output logic              ram_cenb_o,
  output logic              ram_oenb_o,
  output logic              ram_wenb_o,
  output logic [ADDR_W-1:0] ram_addrb_o,
  output logic [DATA_W-1:0] ram_datab_o,
  input  logic [DATA_W-1:0] ram_datab_i
);

  logic gnt0, gnt1;

  db_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0_i (req0_i),
    .req1_i (req1_i),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign gnt0_o = gnt0;
  assign gnt1_o = gnt1;

  // Port-A pin mux: drive the winner's access, otherwise park the port.
  always_comb begin
    ram_cena_o  = 1'b1;
    ram_wena_o  = 1'b1;
    ram_addra_o = '0;
    ram_dataa_o = '0;
    if (gnt0) begin
      ram_cena_o  = 1'b0;
      ram_wena_o  = ~we0_i;
      ram_addra_o = addr0_i;
      ram_dataa_o = wdata0_i;
    end else if (gnt1) begin
      ram_cena_o  = 1'b0;
      ram_wena_o  = ~we1_i;
      ram_addra_o = addr1_i;
      ram_dataa_o = wdata1_i;
    end
  end

  assign ram_oena_o = 1'b0;
  assign rdata_o    = ram_dataa_i;

  logic rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  assign rvalid0_d = gnt0 & ~we0_i;
  assign rvalid1_d = gnt1 & ~we1_i;

  // Track granted reads so data is flagged one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Gating with rst drops any read still in flight when reset arrives.
  assign rvalid0_o = rvalid0_q & ~rst;
  assign rvalid1_o = rvalid1_q & ~rst;

  bst_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              issued_q, issued_d;
  logic [ADDR_W-1:0] b_addr;
  logic              collide;

  // Address arithmetic wraps naturally at 2^ADDR_W; len 0 ends at cnt = all ones.
  assign b_addr  = base_q + cnt_q;
  assign collide = ~ram_cena_o & ~ram_wena_o & (ram_addra_o == b_addr);

  // Burst next-state: latch in IDLE, issue/stall in RUN, one drain cycle.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    issued_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_start_i) begin
          base_d  = rd_base_i;
          len_d   = rd_len_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!collide) begin
          issued_d = 1'b1;
          cnt_d    = cnt_q + ADDR_W'(1);
          if (cnt_q == len_q - ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst engine registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
    end
  end

  assign ram_cenb_o  = ~(issued_d & ~rst);
  assign ram_addrb_o = (state_q == RUN && !rst) ? b_addr : '0;
  assign ram_oenb_o  = 1'b0;
  assign ram_wenb_o  = 1'b1;
  assign ram_datab_o = '0;

  assign rd_busy_o  = (state_q != IDLE) & ~rst;
  assign rd_valid_o = issued_q & ~rst;
  assign rd_done_o  = (state_q == DRAIN) & ~rst;
  assign rd_data_o  = ram_datab_i;

endmodule

// File: tb/tb_db_ram_dp_ctrl.sv
// Scoreboard bench for db_ram_dp_ctrl with a behavioural dual-port RAM.
module tb_db_ram_dp_ctrl;
  localparam int DW = 20;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_i, req1_i, we0_i, we1_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [DW-1:0] wdata0_i, wdata1_i;
  logic          gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [DW-1:0] rdata_o;
  logic          rd_start_i;
  logic [AW-1:0] rd_base_i, rd_len_i;
  logic          rd_busy_o, rd_valid_o, rd_done_o;
  logic [DW-1:0] rd_data_o;
  logic          ram_cena_o, ram_oena_o, ram_wena_o;
  logic [AW-1:0] ram_addra_o;
  logic [DW-1:0] ram_dataa_o, ram_dataa_i;
  logic          ram_cenb_o, ram_oenb_o, ram_wenb_o;
  logic [AW-1:0] ram_addrb_o;
  logic [DW-1:0] ram_datab_o, ram_datab_i;

  always #5 clk = ~clk;

  db_ram_dp_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o), .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
    .rdata_o(rdata_o),
    .rd_start_i(rd_start_i), .rd_base_i(rd_base_i), .rd_len_i(rd_len_i),
    .rd_busy_o(rd_busy_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_done_o(rd_done_o),
    .ram_cena_o(ram_cena_o), .ram_oena_o(ram_oena_o), .ram_wena_o(ram_wena_o),
    .ram_addra_o(ram_addra_o), .ram_dataa_o(ram_dataa_o), .ram_dataa_i(ram_dataa_i),
    .ram_cenb_o(ram_cenb_o), .ram_oenb_o(ram_oenb_o), .ram_wenb_o(ram_wenb_o),
    .ram_addrb_o(ram_addrb_o), .ram_datab_o(ram_datab_o), .ram_datab_i(ram_datab_i)
  );

  // Behavioural RAM: synchronous, read data one cycle after access.
  logic [DW-1:0] mem [128];
  always @(posedge clk) begin
    if (!ram_cena_o) begin
      if (!ram_wena_o) mem[ram_addra_o] <= ram_dataa_o;
      else             ram_dataa_i <= mem[ram_addra_o];
    end
    if (!ram_cenb_o && ram_wenb_o) ram_datab_i <= mem[ram_addrb_o];
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [DW-1:0] shadow [128];
  logic [DW-1:0] q0[$], q1[$], bq[$];
  bit            ptr_m, g0_last, g1_last;
  bit            b_first, b_done_seen;
  int            b_start, b_done_exp;
  bit            eg0, eg1, w_we;
  logic [AW-1:0] w_a;
  logic [DW-1:0] w_d, e_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endtask

  // Monitor: compares every DUT output against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_flags", 64'({gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rd_busy_o, rd_valid_o, rd_done_o}), 64'd0);
      chk("rst_pins", 64'({ram_cena_o, ram_cenb_o, ram_wena_o, ram_wenb_o, ram_oena_o, ram_oenb_o}), 64'b111100);
      chk("rst_bus", 64'({ram_addra_o, ram_addrb_o}), 64'd0);
      chk("rst_data", 64'({ram_dataa_o, ram_datab_o}), 64'd0);
      q0.delete(); q1.delete(); bq.delete();
      ptr_m = 1'b0; b_first = 1'b0; g0_last = 1'b0; g1_last = 1'b0;
    end else begin
      // Port-A read returns from the previous cycle.
      chk("rvalid0", 64'(rvalid0_o), 64'(q0.size() != 0));
      chk("rvalid1", 64'(rvalid1_o), 64'(q1.size() != 0));
      if (q0.size() != 0) begin
        e_d = q0.pop_front();
        if (rvalid0_o) chk("rdata0", 64'(rdata_o), 64'(e_d));
      end
      if (q1.size() != 0) begin
        e_d = q1.pop_front();
        if (rvalid1_o) chk("rdata1", 64'(rdata_o), 64'(e_d));
      end
      // Round robin: a lone requester wins; on contention the pointer's
      // requester wins and the pointer passes to the other one.
      eg0 = req0_i && (!req1_i || ptr_m == 1'b0);
      eg1 = req1_i && (!req0_i || ptr_m == 1'b1);
      if (req0_i && req1_i) ptr_m = ~ptr_m;
      chk("gnt", 64'({gnt0_o, gnt1_o}), 64'({eg0, eg1}));
      g0_last = eg0;
      g1_last = eg1;
      if (eg0 || eg1) begin
        w_we = eg0 ? we0_i : we1_i;
        w_a  = eg0 ? addr0_i : addr1_i;
        w_d  = eg0 ? wdata0_i : wdata1_i;
        chk("a_pins", 64'({ram_cena_o, ram_wena_o, ram_addra_o}), 64'({1'b0, ~w_we, w_a}));
        if (w_we) begin
          chk("a_wdata", 64'(ram_dataa_o), 64'(w_d));
          shadow[w_a] = w_d;
        end else if (eg0) q0.push_back(shadow[w_a]);
        else q1.push_back(shadow[w_a]);
      end else begin
        chk("a_idle", 64'(ram_cena_o), 64'd1);
      end
      chk("b_static", 64'({ram_wenb_o, ram_oenb_o, ram_oena_o, ram_datab_o}), 64'({3'b100, 20'd0}));
      // Burst stream.
      if (rd_valid_o) begin
        if (bq.size() == 0) fail_now("b_spurious_valid");
        else begin
          if (b_first) begin
            chk("b_latency", 64'(cyc), 64'(b_start + 2));
            b_first = 1'b0;
          end
          e_d = bq.pop_front();
          chk("b_data", 64'(rd_data_o), 64'(e_d));
        end
      end
      if (rd_done_o) begin
        b_done_seen = 1'b1;
        chk("b_done_cycle", 64'(cyc), 64'(b_done_exp));
        chk("b_done_last", 64'({rd_valid_o, 7'(bq.size())}), 64'({1'b1, 7'd0}));
      end
    end
  end

  // Queue the expected words for a burst and pulse start.
  task automatic start_burst(input logic [AW-1:0] base, input logic [AW-1:0] len, input int stalls);
    int n;
    n = (len == 0) ? 128 : int'(len);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) bq.push_back(shadow[7'(int'(base) + k)]);
    b_start     = cyc;
    b_first     = 1'b1;
    b_done_seen = 1'b0;
    b_done_exp  = cyc + n + 1 + stalls;
    rd_start_i  = 1'b1;
    rd_base_i   = base;
    rd_len_i    = len;
    @(posedge clk); #1;
    rd_start_i = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((rd_busy_o || bq.size() != 0) && k < maxc);
    if (rd_busy_o || bq.size() != 0) fail_now("burst_timeout");
    chk("b_done_seen", 64'(b_done_seen), 64'd1);
  endtask

  // Random port-A traffic; a pending request is held until granted.
  task automatic rand_porta(input int n, input bit reads_only);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!req0_i || g0_last) begin
        req0_i   = ($urandom_range(0, 3) != 0);
        we0_i    = reads_only ? 1'b0 : 1'($urandom_range(0, 1));
        addr0_i  = 7'($urandom);
        wdata0_i = 20'($urandom);
      end
      if (!req1_i || g1_last) begin
        req1_i   = ($urandom_range(0, 3) != 0);
        we1_i    = reads_only ? 1'b0 : 1'($urandom_range(0, 1));
        addr1_i  = 7'($urandom);
        wdata1_i = 20'($urandom);
      end
    end
    @(posedge clk); #1;
    req0_i = 1'b0;
    req1_i = 1'b0;
  endtask

  initial begin
    req0_i = 0; req1_i = 0; we0_i = 0; we1_i = 0;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    rd_start_i = 0; rd_base_i = '0; rd_len_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Preload data[i] = i through requester 0 only.
    for (int i = 0; i < 128; i++) begin
      @(posedge clk); #1;
      req0_i = 1'b1; we0_i = 1'b1; addr0_i = 7'(i); wdata0_i = 20'(i);
    end
    @(posedge clk); #1 req0_i = 1'b0;

    // Contention: grants alternate 0,1,0,1 from the reset pointer.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      req0_i = 1'b1; we0_i = 1'b0; addr0_i = 7'(k);
      req1_i = 1'b1; we1_i = 1'b0; addr1_i = 7'(k + 64);
      @(negedge clk);
      chk("contention_gnt", 64'({gnt0_o, gnt1_o}), (k % 2 == 0) ? 64'b10 : 64'b01);
    end
    @(posedge clk); #1 req0_i = 1'b0; req1_i = 1'b0;

    // Single write via req0, read back via req1.
    @(posedge clk); #1;
    req0_i = 1'b1; we0_i = 1'b1; addr0_i = 7'd5; wdata0_i = 20'h12345;
    @(posedge clk); #1;
    req0_i = 1'b0; req1_i = 1'b1; we1_i = 1'b0; addr1_i = 7'd5;
    @(negedge clk);
    chk("single_gnt1", 64'(gnt1_o), 64'd1);
    @(posedge clk); #1 req1_i = 1'b0;
    @(negedge clk);
    chk("single_rdata", 64'({rvalid1_o, rdata_o}), 64'({1'b1, 20'h12345}));

    // Wrapping burst 126,127,0,1.
    start_burst(7'd126, 7'd4, 0);
    wait_idle(50);

    // Full 128-word burst with a port-A write colliding on address 10.
    start_burst(7'd0, 7'd0, 1);
    bq[10] = 20'hABCDE;
    repeat (10) @(posedge clk);
    #1;
    req0_i = 1'b1; we0_i = 1'b1; addr0_i = 7'd10; wdata0_i = 20'hABCDE;
    @(posedge clk); #1 req0_i = 1'b0;
    wait_idle(400);

    // Start while busy is ignored.
    start_burst(7'd20, 7'd8, 0);
    @(posedge clk); #1;
    rd_start_i = 1'b1; rd_base_i = 7'd100; rd_len_i = 7'd3;
    @(posedge clk); #1 rd_start_i = 1'b0;
    wait_idle(50);

    // Reset during a 16-word burst, then a clean burst.
    start_burst(7'd40, 7'd16, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'({rd_busy_o, rd_valid_o, rd_done_o, rvalid0_o, rvalid1_o}), 64'd0);
    start_burst(7'd40, 7'd16, 0);
    wait_idle(50);

    // Random port-A traffic, then random bursts alongside random reads.
    rand_porta(300, 1'b0);
    for (int b = 0; b < 6; b++) begin
      fork
        begin
          start_burst(7'($urandom), 7'($urandom_range(0, 24)), 0);
          wait_idle(400);
        end
        rand_porta(30, 1'b1);
      join
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queues_empty", 64'({8'(q0.size()), 8'(q1.size()), 8'(bq.size())}), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
